downcount_timer: RTL and testbench



---
 rtl/downcount_pkg.sv | 13 +
 rtl/downcount_timer_if.sv | 28 ++
 rtl/downcount_timer.sv | 88 ++++++++
 tb/tb_downcount_timer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/downcount_pkg.sv
// Shared types and constants for the loadable down-counter timer.
// Optional auto-reload is enabled by defining DOWNCOUNT_RELOAD_EN.
package downcount_pkg;

   localparam int DOWNCOUNT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COUNT   = 2'd1,
      EXPIRED = 2'd2
   } state_t;

endpackage : downcount_pkg

// File: rtl/downcount_timer_if.sv
// Control/status bundle of the down-counter timer.
// The master drives the load value and strobes; the slave (the timer) returns count and status.
interface downcount_timer_if
   import downcount_pkg::*;
#(
   parameter int WIDTH = DOWNCOUNT_WIDTH
);

   logic [WIDTH-1:0] R;
   logic             l;
   logic             en;
   logic             auto;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             busy;
   logic             done;

   modport master (
      output R, l, en, auto,
      input  q, tc, busy, done
   );

   modport slave (
      input  R, l, en, auto,
      output q, tc, busy, done
   );

endinterface : downcount_timer_if

// File: rtl/downcount_timer.sv
// Loadable down-counter with registered terminal-count pulse.
// A load of R starts counting towards zero; at the terminal decrement the
// timer either expires or (when DOWNCOUNT_RELOAD_EN is defined and auto=1)
// reloads the value captured at the last load. Without DOWNCOUNT_RELOAD_EN
// the reload register is absent and auto is ignored (one-shot only).
module downcount_timer
   import downcount_pkg::*;
#(
   parameter int WIDTH = DOWNCOUNT_WIDTH
) (
   input  logic              clk,
   input  logic              reset,
   downcount_timer_if.slave  bus
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;

`ifdef DOWNCOUNT_RELOAD_EN
   logic [WIDTH-1:0] reload_q, reload_d;
`else
   logic             unused_auto;
   assign unused_auto = bus.auto;
`endif

   // Next-state, next-count and terminal-count pulse; load beats counting.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      tc_d     = 1'b0;
`ifdef DOWNCOUNT_RELOAD_EN
      reload_d = reload_q;
`endif
      if (bus.l) begin
         count_d  = bus.R;
`ifdef DOWNCOUNT_RELOAD_EN
         reload_d = bus.R;
`endif
         // A zero load has nothing to count: expire at once without a pulse.
         state_d  = (bus.R != '0) ? COUNT : EXPIRED;
      end else if (state_q == COUNT && bus.en) begin
         // COUNT is only entered with a nonzero value, so q==0 never occurs here
         // and the counter cannot wrap to all-ones.
         if (count_q == WIDTH'(1)) begin
            tc_d = 1'b1;
`ifdef DOWNCOUNT_RELOAD_EN
            if (bus.auto) begin
               count_d = reload_q;
            end else begin
               count_d = '0;
               state_d = EXPIRED;
            end
`else
            count_d = '0;
            state_d = EXPIRED;
`endif
         end else begin
            count_d = count_q - WIDTH'(1);
         end
      end
   end

   // State, count and pulse registers with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         tc_q     <= 1'b0;
`ifdef DOWNCOUNT_RELOAD_EN
         reload_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         tc_q     <= tc_d;
`ifdef DOWNCOUNT_RELOAD_EN
         reload_q <= reload_d;
`endif
      end
   end

   assign bus.q    = count_q;
   assign bus.tc   = tc_q;
   assign bus.busy = (state_q == COUNT);
   assign bus.done = (state_q == EXPIRED);

endmodule : downcount_timer

// File: tb/tb_downcount_timer.sv
// Self-checking bench for downcount_timer: directed scenarios with literal
// expectations, then randomized load/enable/auto/reset traffic compared every
// cycle against an arithmetic model (enabled-cycle count since the last load).
// Honors DOWNCOUNT_RELOAD_EN the same way the design does.
module tb_downcount_timer;

   localparam int W = 4;

   logic clk;
   logic reset;

   downcount_timer_if #(.WIDTH(W)) bus ();

   downcount_timer #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Timer described as: load value m_r, number of enabled count cycles m_e
   // since the load, and whether a terminal decrement stopped it.
   bit m_loaded;
   int m_r;
   int m_e;
   bit m_stopped;
   bit m_tc;

`ifdef DOWNCOUNT_RELOAD_EN
   function automatic bit auto_eff(input logic a); return a; endfunction
`else
   function automatic bit auto_eff(input logic a); return 1'b0 & a; endfunction
`endif

   function automatic bit m_counting();
      return m_loaded && (m_r != 0) && !m_stopped;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_loaded = 0; m_r = 0; m_e = 0; m_stopped = 0; m_tc = 0;
      end else if (bus.l) begin
         m_loaded = 1; m_r = int'(bus.R); m_e = 0; m_stopped = 0; m_tc = 0;
      end else if (m_counting() && bus.en) begin
         m_e++;
         m_tc = (m_e % m_r) == 0;
         if (m_tc && !auto_eff(bus.auto)) m_stopped = 1;
      end else begin
         m_tc = 0;
      end
   end

   function automatic int exp_q();
      if (!m_counting()) return 0;
      return m_r - (m_e % m_r);
   endfunction

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (!reset) begin
         chk("model_q",    int'(bus.q),    exp_q());
         chk("model_tc",   int'(bus.tc),   int'(m_tc));
         chk("model_busy", int'(bus.busy), int'(m_counting()));
         chk("model_done", int'(bus.done), int'(m_loaded && !m_counting()));
      end
   end

   // ---------------- stimulus helpers ----------------
   bit verbose = 1;

   // One clock cycle: drive inputs after a falling edge, return at the next one.
   task automatic cyc(input logic l_v, input int r_v, input logic en_v, input logic au_v);
      bus.l    = l_v;
      bus.R    = W'(r_v);
      bus.en   = en_v;
      bus.auto = au_v;
      @(negedge clk);
      if (verbose)
         $display("t=%0t l=%0b R=%0d en=%0b auto=%0b -> q=%0d tc=%0b busy=%0b done=%0b",
                  $time, l_v, r_v, en_v, au_v, bus.q, bus.tc, bus.busy, bus.done);
   endtask

   task automatic expect_out(input string name, input int q_e, input int tc_e,
                             input int busy_e, input int done_e);
      chk({name, "_q"},    int'(bus.q),    q_e);
      chk({name, "_tc"},   int'(bus.tc),   tc_e);
      chk({name, "_busy"}, int'(bus.busy), busy_e);
      chk({name, "_done"}, int'(bus.done), done_e);
   endtask

   // Asynchronous reset between clock edges; outputs must clear at once.
   task automatic reset_pulse(input bit check);
      #2 reset = 1'b1;
      #1;
      if (check) expect_out("async_rst", 0, 0, 0, 0);
      @(negedge clk);
      #2 reset = 1'b0;
   endtask

   initial begin
      bus.l = 0; bus.R = '0; bus.en = 0; bus.auto = 0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      expect_out("reset", 0, 0, 0, 0);

      // Idle ignores enable.
      cyc(0, 0, 1, 0); expect_out("idle_en", 0, 0, 0, 0);

      // One-shot from 3.
      cyc(1, 3, 1, 0); expect_out("os_3",  3, 0, 1, 0);
      cyc(0, 9, 1, 0); expect_out("os_2",  2, 0, 1, 0);
      cyc(0, 9, 1, 0); expect_out("os_1",  1, 0, 1, 0);
      cyc(0, 9, 1, 0); expect_out("os_0",  0, 1, 0, 1);
      cyc(0, 9, 1, 0); expect_out("os_hold", 0, 0, 0, 1);
      cyc(0, 9, 1, 1); expect_out("os_nowrap", 0, 0, 0, 1);

      // Auto-reload from 2.
      cyc(1, 2, 1, 1); expect_out("ar_2a", 2, 0, 1, 0);
      cyc(0, 7, 1, 1); expect_out("ar_1a", 1, 0, 1, 0);
`ifdef DOWNCOUNT_RELOAD_EN
      cyc(0, 7, 1, 1); expect_out("ar_2b", 2, 1, 1, 0);
      cyc(0, 7, 1, 1); expect_out("ar_1b", 1, 0, 1, 0);
      cyc(0, 7, 1, 1); expect_out("ar_2c", 2, 1, 1, 0);
`else
      cyc(0, 7, 1, 1); expect_out("ar_stop", 0, 1, 0, 1);
      cyc(0, 7, 1, 1); expect_out("ar_hold", 0, 0, 0, 1);
`endif

      // Enable gating from 4.
      cyc(1, 4, 1, 0); expect_out("en_4",  4, 0, 1, 0);
      cyc(0, 0, 1, 0); expect_out("en_3a", 3, 0, 1, 0);
      cyc(0, 0, 0, 0); expect_out("en_3b", 3, 0, 1, 0);
      cyc(0, 0, 0, 0); expect_out("en_3c", 3, 0, 1, 0);
      cyc(0, 0, 1, 0); expect_out("en_2",  2, 0, 1, 0);

      // Zero load expires without a pulse.
      cyc(1, 0, 1, 0); expect_out("zero_a", 0, 0, 0, 1);
      cyc(0, 0, 1, 0); expect_out("zero_b", 0, 0, 0, 1);

      // Load coincident with terminal decrement.
      cyc(1, 1, 1, 0); expect_out("lt_1", 1, 0, 1, 0);
      cyc(1, 6, 1, 0); expect_out("lt_6", 6, 0, 1, 0);

      // All-ones period is 2^W-1 enabled cycles.
      cyc(1, 15, 1, 0);
      repeat (14) cyc(0, 0, 1, 0);
      expect_out("full_1", 1, 0, 1, 0);
      cyc(0, 0, 1, 0); expect_out("full_0", 0, 1, 0, 1);

      // Reset mid-count at q=5.
      cyc(1, 5, 0, 0); expect_out("pre_rst", 5, 0, 1, 0);
      reset_pulse(1);
      cyc(0, 0, 1, 0); expect_out("post_rst", 0, 0, 0, 0);

      // Randomized traffic, checked by the every-cycle model comparison.
      verbose = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            reset_pulse(1);
         end else begin
            int r_v;
            r_v = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 15));
            cyc(($urandom_range(0, 7) == 0), r_v, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_downcount_timer
